// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write port.
package regfile_pkg;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned WRCNT_W      = 16;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;
endpackage

// File: rtl/regfile_write_port_dec.sv
// Combinational 5-to-32 one-hot decoder with enable.
module addr_decoder_5to32
  import regfile_pkg::*;
(
  input  logic                    en_i,
  input  logic [ADDR_W-1:0]       addr_i,
  output logic [(1<<ADDR_W)-1:0]  onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x 32 register file with sequenced bulk clear.
// Optional feature: define REGFILE_WRCNT_EN to add the wr_count output.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done,
`ifdef REGFILE_WRCNT_EN
  output logic [WRCNT_W-1:0]         wr_count,
`endif
  output logic [NUM_REGS*DATA_W-1:0] q
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_oh, clr_oh, reg_en;
  logic [DATA_W-1:0]   wr_val;
  logic                wr_fire;

  assign wr_ready = !reset && (state_q == IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = ADDR_W'(1);
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        if (clr_cnt_q == '1) begin
          clear_done = 1'b1;
          state_d    = IDLE;
          clr_cnt_d  = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  addr_decoder_5to32 u_wr_dec (
    .en_i     (wr_fire),
    .addr_i   (wr_addr),
    .onehot_o (wr_oh)
  );

  addr_decoder_5to32 u_clr_dec (
    .en_i     (clear_busy),
    .addr_i   (clr_cnt_q),
    .onehot_o (clr_oh)
  );

  // Writes and clears never overlap (wr_ready is low in CLEAR), so one shared
  // data value suffices; entry 0 only ever loads zero and so stays zero.
  assign reg_en = wr_oh | clr_oh;
  assign wr_val = clear_busy ? '0 : wr_data;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset)          regs_q[i] <= '0;
      else if (reg_en[i]) regs_q[i] <= (i == 0) ? '0 : wr_val;
    end
  end

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) q[i*DATA_W +: DATA_W] = regs_q[i];
  end

`ifdef REGFILE_WRCNT_EN
  logic [WRCNT_W-1:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (reset)
      wr_count_q <= '0;
    else if (wr_fire && (wr_addr != '0) && (wr_count_q != '1))
      wr_count_q <= wr_count_q + WRCNT_W'(1);
  end

  assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port.
module tb_regfile_write_port;
  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         clear_req;
  logic         clear_busy;
  logic         clear_done;
  logic [1023:0] q;
`ifdef REGFILE_WRCNT_EN
  logic [15:0]  wr_count;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_port #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
`ifdef REGFILE_WRCNT_EN
    .wr_count   (wr_count),
`endif
    .q          (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return q[i*32 +: 32];
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int low_cnt, busy_cnt, done_cnt, done_at, waited;
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_done", {31'd0, clear_done}, 32'd0);
    chk("rst_r5", rd(5), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready", {31'd0, wr_ready}, 32'd1);

    write(5'd5, 32'hDEADBEEF);
    chk("w5_r5", rd(5), 32'hDEADBEEF);
    chk("w5_r4", rd(4), 32'd0);
    chk("w5_r6", rd(6), 32'd0);
    chk("w5_r0", rd(0), 32'd0);

    write(5'd0, 32'hFFFFFFFF);
    chk("w0_r0", rd(0), 32'd0);
    chk("w0_ready", {31'd0, wr_ready}, 32'd1);
`ifdef REGFILE_WRCNT_EN
    chk("w0_cnt", {16'd0, wr_count}, 32'd1);
`endif

    for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
    chk("fill_r1", rd(1), 32'd1);
    chk("fill_r17", rd(17), 32'd17);
    chk("fill_r31", rd(31), 32'd31);
`ifdef REGFILE_WRCNT_EN
    chk("fill_cnt", {16'd0, wr_count}, 32'd32);
`endif

    // Bulk clear, with a stray clear_req mid-way that must be ignored.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    low_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!wr_ready) low_cnt++;
      if (clear_busy) busy_cnt++;
      if (clear_done) begin done_cnt++; done_at = k; end
      clear_req = (k == 5);
      tick();
    end
    clear_req = 1'b0;
    chk("clr_low", 32'(low_cnt), 32'd31);
    chk("clr_busy", 32'(busy_cnt), 32'd31);
    chk("clr_done_n", 32'(done_cnt), 32'd1);
    chk("clr_done_at", 32'(done_at), 32'd31);
    for (int i = 0; i < 32; i++) chk($sformatf("clr_r%0d", i), rd(i), 32'd0);
`ifdef REGFILE_WRCNT_EN
    chk("clr_cnt", {16'd0, wr_count}, 32'd32);
`endif

    // Write and clear_req in the same IDLE cycle.
    wr_valid  = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'h12345678;
    clear_req = 1'b1;
    tick();
    wr_valid  = 1'b0;
    clear_req = 1'b0;
    chk("same_r7", rd(7), 32'h12345678);
    chk("same_busy", {31'd0, clear_busy}, 32'd1);
    waited = 0;
    while (clear_busy && waited < 40) begin tick(); waited++; end
    chk("same_timeout", {31'd0, clear_busy}, 32'd0);
    chk("same_r7_clr", rd(7), 32'd0);

    // Reset during clear cycle 10; write and clear_req held during reset.
    write(5'd20, 32'h0000AAAA);
    write(5'd3, 32'd5);
    chk("pre_r20", rd(20), 32'h0000AAAA);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    reset     = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'd1;
    clear_req = 1'b1;
    tick();
    chk("mid_busy", {31'd0, clear_busy}, 32'd0);
    chk("mid_ready", {31'd0, wr_ready}, 32'd0);
    chk("mid_r9", rd(9), 32'd0);
    reset     = 1'b0;
    wr_valid  = 1'b0;
    clear_req = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, wr_ready}, 32'd1);
    chk("mid_r20", rd(20), 32'd0);
    chk("mid_r3", rd(3), 32'd0);
    tick();
    chk("mid_rel_busy", {31'd0, clear_busy}, 32'd0);
`ifdef REGFILE_WRCNT_EN
    chk("mid_cnt", {16'd0, wr_count}, 32'd0);

    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'hC0FFEE;
    for (int n = 0; n < 65534; n++) tick();
    chk("sat_fffe", {16'd0, wr_count}, 32'h0000FFFE);
    for (int n = 0; n < 4466; n++) tick();
    wr_valid = 1'b0;
    chk("sat_ffff", {16'd0, wr_count}, 32'h0000FFFF);
    chk("sat_r3", rd(3), 32'hC0FFEE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
